// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq
// Brief   : Handshaked ADD/SUB/NEG ALU with a multi-cycle shift-add unsigned MUL.
// Revision: 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_last   = CW'(WIDTH - 1);
    localparam logic [1:0]     c_op_sub = 2'b01;
    localparam logic [1:0]     c_op_neg = 2'b10;
    localparam logic [1:0]     c_op_mul = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;

    logic [WIDTH-1:0]     w_x;
    logic [WIDTH-1:0]     w_y;
    logic                 w_cin;
    logic [WIDTH:0]       w_sum;
    logic                 w_ovf;
    logic [2*WIDTH-1:0]   w_acc_next;

    // ADD, SUB and NEG all share one adder: x + y + cin.
    always_comb begin
        w_x   = a;
        w_y   = b;
        w_cin = 1'b0;
        case (op)
            c_op_sub: begin
                w_y   = ~b;
                w_cin = 1'b1;
            end
            c_op_neg: begin
                w_x   = ~a;
                w_y   = '0;
                w_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

    // For NEG (x=~a, y=0) this fires only for a == 100..0.
    assign w_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) & (w_sum[WIDTH-1] != w_x[WIDTH-1]);

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {2*WIDTH{1'b0}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            result   <= '0;
            cout     <= 1'b0;
            zero     <= 1'b0;
            ovf      <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == c_op_mul) begin
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, a};
                            r_mplier <= b;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            result  <= w_sum[WIDTH-1:0];
                            cout    <= w_sum[WIDTH];
                            zero    <= (w_sum[WIDTH-1:0] == '0);
                            ovf     <= w_ovf;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        result  <= w_acc_next[WIDTH-1:0];
                        cout    <= |w_acc_next[2*WIDTH-1:WIDTH];
                        zero    <= (w_acc_next[WIDTH-1:0] == '0);
                        ovf     <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 8-bit adder/negator/subtractor set.
- Performs ADD, SUB, NEG and unsigned MUL on WIDTH-bit operands and reports carry, zero and signed-overflow flags.
- ADD/SUB/NEG complete in one cycle; MUL is a multi-cycle shift-add sequence.
- Sits between an operand source and a result sink, each using a valid/ready handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal: WIDTH >= 2)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand source has a command
- in_ready  out  1  block can accept a command
- op  in  2  opcode: 00 ADD, 01 SUB, 10 NEG, 11 MUL
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored for NEG)
- out_valid  out  1  result and flags valid
- out_ready  in  1  sink accepts the result
- result  out  WIDTH  low WIDTH bits of the operation
- cout  out  1  carry flag (defined per op below)
- zero  out  1  result == 0
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1.
  - out_valid=0; result=0; cout=0; zero=0; ovf=0.
  - MUL counter and accumulators cleared.
  - Takes effect immediately, including mid-MUL or while a result is held; the in-flight command is discarded.
- States: IDLE, MUL, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Accept: an edge with in_valid & in_ready latches op, a, b.
  - ADD/SUB/NEG: go to DONE; out_valid is high in the next cycle (1-cycle latency).
  - MUL: go to MUL; counter=0.
- MUL state:
  - Each edge: if multiplier LSB=1, add the multiplicand to the 2*WIDTH-bit accumulator; shift the multiplicand left 1 and the multiplier right 1; counter++.
  - After exactly WIDTH edges in MUL, go to DONE. out_valid rises WIDTH+1 edges after the accept edge.
  - in_valid is ignored while in MUL.
- DONE:
  - result and flags hold stable while out_ready=0.
  - An edge with out_ready=1 goes to IDLE and clears out_valid.
  - No same-cycle accept: a new command can be taken no earlier than the edge after the handshake.
- Arithmetic, all mod 2^WIDTH:
  - ADD: result=a+b; cout=carry out of the MSB; ovf=(a[MSB]==b[MSB]) & (result[MSB]!=a[MSB]).
  - SUB: computed as a+~b+1; cout=carry out (1 = no borrow, i.e. a>=b unsigned); ovf=(a[MSB]!=b[MSB]) & (result[MSB]!=a[MSB]).
  - NEG: computed as ~a+1; cout=1 only when a==0; ovf=1 only when a==100..0 (most negative value).
  - MUL: unsigned; result=low WIDTH bits of the product; cout=1 if the high WIDTH bits are nonzero; ovf=0.
  - zero is computed from result for every op.
- Boundary cases:
  - out_ready may be held high permanently: DONE lasts exactly one cycle.
  - in_valid held high continuously: commands are accepted on every other edge for single-cycle ops.
  - Operand changes after the accept edge do not affect the computation.
  - Undriven op is out of scope; all four encodings are defined.

Test Plan:
- Reset/idle: rst_n=0 -> out_valid=0, in_ready=1, result=0. Release reset -> outputs unchanged until a command is accepted.
- ADD (WIDTH=8):
  - 200+100 -> result=44, cout=1, ovf=0, zero=0, out_valid one cycle after accept.
  - 100+100 -> result=200, cout=0, ovf=1.
- SUB:
  - 5-7 -> result=254, cout=0, ovf=0.
  - 0x80-0x01 -> result=0x7F, cout=1, ovf=1.
  - 9-9 -> result=0, zero=1, cout=1.
- NEG:
  - a=0x80 -> result=0x80, ovf=1, cout=0.
  - a=0 -> result=0, zero=1, cout=1.
  - a=1 -> result=0xFF.
- MUL:
  - 13*11 -> result=143, cout=0; out_valid exactly 9 edges after accept; in_ready=0 throughout.
  - 20*20 -> result=144, cout=1.
  - 255*0 -> result=0, zero=1.
- Backpressure and reset:
  - out_ready=0 for 3 cycles in DONE -> result/flags stable, in_ready=0. Raise out_ready -> IDLE next edge.
  - Assert rst_n=0 mid-MUL (after 4 iterations) -> out_valid=0 and in_ready=1 immediately.
  - After release, a new ADD 1+1 -> result=2.
